// File: rtl/mem_arbiter.sv
// Slot-multiplexed arbiter sharing one synchronous memory between the VGA fetch path and a CPU port.
// Optional build macro ARB_STATS_EN adds a saturating CPU stall counter output (stall_cnt).
module mem_arbiter #(
  parameter int          DATAWIDTH     = 16,
  parameter int          ADDRWIDTH     = 16,
  parameter logic [7:0]  CPU_SLOT_MASK = 8'b1111_1001
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [2:0]           acnt,
  input  logic [ADDRWIDTH-1:0] vga_addr,
  output logic [DATAWIDTH-1:0] glyph_num,
  output logic [DATAWIDTH-1:0] glyph_pixels,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDRWIDTH-1:0] cpu_addr,
  input  logic [DATAWIDTH-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [DATAWIDTH-1:0] cpu_rdata,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic                 mem_we,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic [DATAWIDTH-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  // Slots 1 and 2 always belong to the VGA path, whatever the mask says.
  localparam logic [7:0] SLOT_MASK = CPU_SLOT_MASK & 8'b1111_1001;

  logic                 vga_slot;
  logic                 cpu_slot;
  logic                 rd_pend;
  logic [DATAWIDTH-1:0] rdata_q;

  assign vga_slot  = (acnt == 3'd1) || (acnt == 3'd2);
  assign cpu_slot  = SLOT_MASK[acnt];

  assign cpu_gnt   = cpu_req & cpu_slot;
  assign mem_addr  = vga_slot ? vga_addr : cpu_addr;
  assign mem_we    = cpu_gnt & cpu_we;
  assign mem_wdata = cpu_wdata;

  // Read data is forwarded from memory in the valid cycle and held afterwards.
  assign cpu_rvalid = rd_pend;
  assign cpu_rdata  = rd_pend ? mem_rdata : rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acnt         <= 3'd0;
      rd_pend      <= 1'b0;
      rdata_q      <= '0;
      glyph_num    <= '0;
      glyph_pixels <= '0;
    end else begin
      acnt    <= acnt + 3'd1;
      rd_pend <= cpu_gnt & ~cpu_we;
      if (rd_pend)
        rdata_q <= mem_rdata;
      if (acnt == 3'd2)
        glyph_num <= mem_rdata;
      if (acnt == 3'd3)
        glyph_pixels <= mem_rdata;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= 16'd0;
    else if (cpu_req && !cpu_gnt && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: slot-level reference model, vector table and directed sequences.
// Stall-counter checks are compiled in when ARB_STATS_EN is defined.
module tb_mem_arbiter;

  localparam logic [7:0] MASK = 8'b1111_1001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  acnt;
  logic [15:0] vga_addr = 16'h0;
  logic [15:0] glyph_num, glyph_pixels;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [2:0]  sat_acnt;
  logic [15:0] sat_gn, sat_gp, sat_rdata, sat_maddr, sat_mwdata, sat_stall;
  logic        sat_gnt, sat_rvalid, sat_mwe;
  logic        sat_req = 1'b1;
`endif

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .acnt(acnt), .vga_addr(vga_addr),
    .glyph_num(glyph_num), .glyph_pixels(glyph_pixels),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

`ifdef ARB_STATS_EN
  // CPU never gets a slot here, so every cycle of a held request is a stall.
  mem_arbiter #(.CPU_SLOT_MASK(8'h00)) sat_dut (
    .clk(clk), .rst(rst), .acnt(sat_acnt), .vga_addr(16'h0),
    .glyph_num(sat_gn), .glyph_pixels(sat_gp),
    .cpu_req(sat_req), .cpu_we(1'b0), .cpu_addr(16'h0), .cpu_wdata(16'h0),
    .cpu_gnt(sat_gnt), .cpu_rvalid(sat_rvalid), .cpu_rdata(sat_rdata),
    .mem_addr(sat_maddr), .mem_we(sat_mwe), .mem_wdata(sat_mwdata), .mem_rdata(16'h0),
    .stall_cnt(sat_stall)
  );
`endif

  // Memory seen by the DUT, and the model's own view of what it should contain.
  logic [15:0] sram   [0:65535];
  logic [15:0] shadow [0:65535];

  int passed = 0;
  int total  = 0;

  int          m_slot;
  bit          m_gnt, m_rv;
  logic [15:0] m_rd, m_gn, m_gp, m_v1, m_v2;
  int          m_stall;
  bit          rand_mode = 1'b0;

  logic [15:0] s_addr, s_wdata;
  logic        s_we;

  typedef struct {
    int          slot;
    bit          req;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          exp_gnt;
    bit          exp_we;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (slot %0d)", name, act, exp, m_slot);
  endtask

  function automatic bit cpu_slot_ok(input int s);
    return MASK[s] && (s != 1) && (s != 2);
  endfunction

  task automatic model_reset();
    m_slot = 0; m_gnt = 0; m_rv = 0; m_rd = 16'h0;
    m_gn = 16'h0; m_gp = 16'h0; m_v1 = 16'h0; m_v2 = 16'h0; m_stall = 0;
  endtask

  task automatic drive_vga();
    vga_addr = (m_slot == 1) ? 16'h0100 : (m_slot == 2) ? 16'h0200 : 16'h0F0F;
  endtask

  // Negedge: compare all DUT outputs of the current slot against the model.
  task automatic sample();
    @(negedge clk);
    s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
    m_gnt = cpu_req && cpu_slot_ok(m_slot);
    checkOutput("acnt", 16'(acnt), 16'(m_slot));
    checkOutput("cpu_gnt", 16'(cpu_gnt), 16'(m_gnt));
    checkOutput("mem_we", 16'(mem_we), 16'(m_gnt && cpu_we));
    checkOutput("mem_addr", mem_addr, (m_slot == 1 || m_slot == 2) ? vga_addr : cpu_addr);
    if (m_slot != 1 && m_slot != 2)
      checkOutput("mem_wdata", mem_wdata, cpu_wdata);
    checkOutput("cpu_rvalid", 16'(cpu_rvalid), 16'(m_rv));
    if (m_rv)
      checkOutput("cpu_rdata", cpu_rdata, m_rd);
    checkOutput("glyph_num", glyph_num, m_gn);
    checkOutput("glyph_pixels", glyph_pixels, m_gp);
`ifdef ARB_STATS_EN
    checkOutput("stall_cnt", stall_cnt, 16'(m_stall));
`endif
  endtask

  // Just after posedge: memory responds, model advances one slot.
  task automatic advance();
    bit          rv_n;
    logic [15:0] rd_n;
    @(posedge clk);
    #1;
    mem_rdata = sram[s_addr];
    if (s_we) sram[s_addr] = s_wdata;
    rv_n = m_gnt && !cpu_we;
    rd_n = shadow[cpu_addr];
    if (m_slot == 2) m_gn = m_v1;
    if (m_slot == 3) m_gp = m_v2;
    if (m_slot == 1) m_v1 = shadow[vga_addr];
    if (m_slot == 2) m_v2 = shadow[vga_addr];
    if (m_gnt && cpu_we) shadow[cpu_addr] = cpu_wdata;
    if (cpu_req && !m_gnt && m_stall < 65535) m_stall++;
    m_rv = rv_n;
    m_rd = rd_n;
    m_slot = (m_slot + 1) % 8;
    if (!rand_mode) drive_vga();
  endtask

  task automatic applyStimulus(input bit req, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic goto_slot(input int s);
    for (int i = 0; i < 8 && m_slot != s; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i]   = 16'(i * 7 + 3);
      shadow[i] = sram[i];
    end
    sram[16'h0100] = 16'h1234; shadow[16'h0100] = 16'h1234;
    sram[16'h0200] = 16'hABCD; shadow[16'h0200] = 16'hABCD;
    sram[16'h0300] = 16'h5A5A; shadow[16'h0300] = 16'h5A5A;

    vecs[0] = '{0, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b1, 1'b0, 16'h0300};
    vecs[1] = '{1, 1'b1, 1'b1, 16'h0040, 16'h3333, 1'b0, 1'b0, 16'h0100};
    vecs[2] = '{2, 1'b1, 1'b0, 16'h0041, 16'h0000, 1'b0, 1'b0, 16'h0200};
    vecs[3] = '{3, 1'b1, 1'b1, 16'h0050, 16'h1111, 1'b1, 1'b1, 16'h0050};
    vecs[4] = '{4, 1'b0, 1'b1, 16'h0060, 16'h4444, 1'b0, 1'b0, 16'h0060};
    vecs[5] = '{5, 1'b1, 1'b0, 16'h0070, 16'h0000, 1'b1, 1'b0, 16'h0070};
    vecs[6] = '{6, 1'b1, 1'b1, 16'h0080, 16'h2222, 1'b1, 1'b1, 16'h0080};
    vecs[7] = '{7, 1'b0, 1'b0, 16'h0090, 16'h0000, 1'b0, 1'b0, 16'h0090};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset acnt", 16'(acnt), 16'h0);
    checkOutput("reset glyph_num", glyph_num, 16'h0);
    checkOutput("reset glyph_pixels", glyph_pixels, 16'h0);
    checkOutput("reset rvalid", 16'(cpu_rvalid), 16'h0);
    checkOutput("reset rdata", cpu_rdata, 16'h0);
    rst = 1'b1;
    drive_vga();

    // Idle traffic: counter walks 0..7 twice, no writes.
    repeat (16) cycle();

    // Glyph capture from the slot-1 and slot-2 VGA addresses.
    goto_slot(3);
    sample();
    checkOutput("glyph_num slot3", glyph_num, 16'h1234);
    advance();
    sample();
    checkOutput("glyph_num slot4", glyph_num, 16'h1234);
    checkOutput("glyph_pixels slot4", glyph_pixels, 16'hABCD);
    advance();

    // Vector table: one access attempt per slot.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
      goto_slot(vecs[i].slot);
      applyStimulus(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      sample();
      checkOutput($sformatf("vec%0d gnt", i), 16'(cpu_gnt), 16'(vecs[i].exp_gnt));
      checkOutput($sformatf("vec%0d we", i), 16'(mem_we), 16'(vecs[i].exp_we));
      checkOutput($sformatf("vec%0d addr", i), mem_addr, vecs[i].exp_addr);
      advance();
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);

    // Read raised in slot 1 waits through the VGA slots, granted in slot 3.
    goto_slot(1);
    applyStimulus(1'b1, 1'b0, 16'h0300, 16'h0);
    sample(); checkOutput("rd gnt slot1", 16'(cpu_gnt), 16'h0); advance();
    sample(); checkOutput("rd gnt slot2", 16'(cpu_gnt), 16'h0); advance();
    sample(); checkOutput("rd gnt slot3", 16'(cpu_gnt), 16'h1); advance();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    sample();
    checkOutput("rd rvalid slot4", 16'(cpu_rvalid), 16'h1);
    checkOutput("rd rdata slot4", cpu_rdata, 16'h5A5A);
    advance();
    sample(); checkOutput("rd rvalid slot5", 16'(cpu_rvalid), 16'h0); advance();

    // Write then read-back in consecutive CPU slots.
    goto_slot(4);
    applyStimulus(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    sample(); checkOutput("wr mem_we slot4", 16'(mem_we), 16'h1); advance();
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0);
    sample();
    checkOutput("rb gnt slot5", 16'(cpu_gnt), 16'h1);
    checkOutput("rb mem_we slot5", 16'(mem_we), 16'h0);
    advance();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    sample();
    checkOutput("rb rvalid slot6", 16'(cpu_rvalid), 16'h1);
    checkOutput("rb rdata slot6", cpu_rdata, 16'hBEEF);
    advance();

    // Reset asserted in the cycle after a read grant.
    goto_slot(3);
    applyStimulus(1'b1, 1'b0, 16'h0300, 16'h0);
    sample();
    advance();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst acnt", 16'(acnt), 16'h0);
    checkOutput("midrst rvalid", 16'(cpu_rvalid), 16'h0);
    checkOutput("midrst rdata", cpu_rdata, 16'h0);
    checkOutput("midrst glyph_num", glyph_num, 16'h0);
    checkOutput("midrst glyph_pixels", glyph_pixels, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    drive_vga();
    repeat (10) cycle();

    // Randomized traffic, including withdrawn requests and VGA reads of CPU-written words.
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 31)), 16'($urandom));
      vga_addr = 16'($urandom_range(0, 31));
      cycle();
    end
    rand_mode = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);

`ifdef ARB_STATS_EN
    repeat (70010) @(posedge clk);
    #1;
    checkOutput("stall_cnt saturate", sat_stall, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
